// File: rtl/bresenham_stepper_pkg.sv
// Shared defaults, FSM states and the normalised-point record for the
// Bresenham ray-tracing path (stepper and downstream flip stage).
package bresenham_pkg;

    localparam int DEF_X_WIDTH = 8;
    localparam int DEF_Y_WIDTH = 7;
    localparam int ERR_WIDTH   = DEF_X_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_X_WIDTH-1:0] x;
        logic [DEF_Y_WIDTH-1:0] y;
        logic                   flip_x;
        logic                   flip_y;
        logic                   flip_identity;
        logic                   last;
    } norm_point_t;

endpackage

// File: rtl/bresenham_stepper_if.sv
// Line-request and normalised-point streams between the stepper, its
// requester and the flip stage.
interface bresenham_stepper_if
    import bresenham_pkg::*;
#(
    parameter int X_WIDTH = DEF_X_WIDTH,
    parameter int Y_WIDTH = DEF_Y_WIDTH
) ();

    logic               line_valid;
    logic               line_ready;
    logic [X_WIDTH-1:0] dx;
    logic [Y_WIDTH-1:0] dy;
    logic               pt_valid;
    logic               pt_ready;
    logic [X_WIDTH-1:0] x_norm;
    logic [Y_WIDTH-1:0] y_norm;
    logic               flip_x;
    logic               flip_y;
    logic               flip_identity;
    logic               pt_last;

    modport slave (
        input  line_valid, dx, dy, pt_ready,
        output line_ready, pt_valid, x_norm, y_norm,
               flip_x, flip_y, flip_identity, pt_last
    );

    modport master (
        output line_valid, dx, dy, pt_ready,
        input  line_ready, pt_valid, x_norm, y_norm,
               flip_x, flip_y, flip_identity, pt_last
    );

endinterface

// File: rtl/bresenham_stepper_octant_normalize.sv
// Folds a signed (dx, dy) offset into the first octant: major/minor lengths,
// flip flags and the initial Bresenham error term.
module octant_normalize #(
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 7,
    parameter int ERR_W   = X_WIDTH + 2
) (
    input  logic                    [X_WIDTH-1:0] dx,
    input  logic                    [Y_WIDTH-1:0] dy,
    output logic                    [X_WIDTH-1:0] a,
    output logic                    [Y_WIDTH-1:0] b,
    output logic                                  swap,
    output logic                                  flip_x,
    output logic                                  flip_y,
    output logic signed             [ERR_W-1:0]   err_init
);

    logic               dx_neg;
    logic               dy_neg;
    logic [X_WIDTH-1:0] ax;
    logic [Y_WIDTH-1:0] ay;
    logic [X_WIDTH-1:0] ay_ext;

    assign dx_neg = dx[X_WIDTH-1];
    assign dy_neg = dy[Y_WIDTH-1];

    // Magnitudes are unsigned, so the most negative input still fits.
    assign ax     = dx_neg ? (~dx + 1'b1) : dx;
    assign ay     = dy_neg ? (~dy + 1'b1) : dy;
    assign ay_ext = {{(X_WIDTH-Y_WIDTH){1'b0}}, ay};

    assign swap   = ay_ext > ax;
    assign a      = swap ? ay_ext : ax;
    // When swapped, ax < ay so it fits the minor-axis width.
    assign b      = swap ? ax[Y_WIDTH-1:0] : ay;
    assign flip_x = swap ? dy_neg : dx_neg;
    assign flip_y = swap ? dx_neg : dy_neg;

    assign err_init = $signed({{(ERR_W-Y_WIDTH-1){1'b0}}, b, 1'b0})
                    - $signed({{(ERR_W-X_WIDTH){1'b0}}, a});

endmodule

// File: rtl/bresenham_stepper.sv
// Bresenham line stepper: one first-octant cell per handshake plus flip flags.
// Define BRESENHAM_OMIT_END_EN to drop the endpoint (free-space-only marking).
//
// state | meaning
// IDLE  | waiting for a line request, line_ready high
// SETUP | octant normalisation of the latched offset, loads major/minor/error
// STEP  | presenting points, advancing on each pt_valid & pt_ready
module bresenham_stepper
    import bresenham_pkg::*;
#(
    parameter int X_WIDTH = DEF_X_WIDTH,
    parameter int Y_WIDTH = DEF_Y_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    bresenham_stepper_if.slave   bus
);

    localparam int ERR_W = X_WIDTH + 2;

    state_t                    state_q, state_nxt;
    logic        [X_WIDTH-1:0] dx_q;
    logic        [Y_WIDTH-1:0] dy_q;
    logic        [X_WIDTH-1:0] a_q;
    logic        [Y_WIDTH-1:0] b_q;
    logic signed [ERR_W-1:0]   err_q;
    logic        [X_WIDTH-1:0] x_q;
    logic        [Y_WIDTH-1:0] y_q;
    logic                      fx_q, fy_q, fi_q;

    logic        [X_WIDTH-1:0] norm_a;
    logic        [Y_WIDTH-1:0] norm_b;
    logic                      norm_swap, norm_fx, norm_fy;
    logic signed [ERR_W-1:0]   norm_err;

    logic                      line_accept, setup_load, step_adv;
    logic                      pt_valid, pt_last, pt_hs;
    logic        [X_WIDTH-1:0] x_end;
    logic signed [ERR_W-1:0]   two_a, two_b;

    octant_normalize #(
        .X_WIDTH (X_WIDTH),
        .Y_WIDTH (Y_WIDTH),
        .ERR_W   (ERR_W)
    ) u_norm (
        .dx       (dx_q),
        .dy       (dy_q),
        .a        (norm_a),
        .b        (norm_b),
        .swap     (norm_swap),
        .flip_x   (norm_fx),
        .flip_y   (norm_fy),
        .err_init (norm_err)
    );

`ifdef BRESENHAM_OMIT_END_EN
    assign x_end = a_q - 1'b1;
`else
    assign x_end = a_q;
`endif

    assign pt_valid = (state_q == STEP);
    assign pt_last  = pt_valid && (x_q == x_end);
    assign pt_hs    = pt_valid && bus.pt_ready;
    assign two_a    = $signed({{(ERR_W-X_WIDTH-1){1'b0}}, a_q, 1'b0});
    assign two_b    = $signed({{(ERR_W-Y_WIDTH-1){1'b0}}, b_q, 1'b0});

    always_comb begin
        state_nxt   = state_q;
        line_accept = 1'b0;
        setup_load  = 1'b0;
        step_adv    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.line_valid) begin
                    line_accept = 1'b1;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                setup_load = 1'b1;
                state_nxt  = STEP;
`ifdef BRESENHAM_OMIT_END_EN
                if (norm_a == '0) state_nxt = IDLE;
`endif
            end
            STEP: begin
                if (pt_hs) begin
                    if (pt_last) state_nxt = IDLE;
                    else         step_adv  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dx_q    <= '0;
            dy_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fx_q    <= 1'b0;
            fy_q    <= 1'b0;
            fi_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (line_accept) begin
                dx_q <= bus.dx;
                dy_q <= bus.dy;
            end
            if (setup_load) begin
                a_q   <= norm_a;
                b_q   <= norm_b;
                err_q <= norm_err;
                fx_q  <= norm_fx;
                fy_q  <= norm_fy;
                fi_q  <= norm_swap;
                x_q   <= '0;
                y_q   <= '0;
            end
            if (step_adv) begin
                x_q <= x_q + 1'b1;
                if (!err_q[ERR_W-1] && (err_q != '0)) begin
                    y_q   <= y_q + 1'b1;
                    err_q <= err_q + two_b - two_a;
                end else begin
                    err_q <= err_q + two_b;
                end
            end
        end
    end

    assign bus.line_ready    = (state_q == IDLE);
    assign bus.pt_valid      = pt_valid;
    assign bus.pt_last       = pt_last;
    assign bus.x_norm        = x_q;
    assign bus.y_norm        = y_q;
    assign bus.flip_x        = fx_q;
    assign bus.flip_y        = fy_q;
    assign bus.flip_identity = fi_q;

endmodule

// File: doc/bresenham_stepper.md
Name: bresenham_stepper

Overview:
- Ray-tracing stage directly upstream of the index-flip stage in the Bresenham scan-matching path.
- Accepts a signed line offset (dx, dy) from the sensor cell to the hit cell and normalises it to the first octant.
- Emits one normalised cell coordinate per cycle, plus the three flip flags, over a valid/ready stream.
- The flip stage maps each coordinate back to true map-relative offsets.

Parameters:
- X_WIDTH, 8, width of x offsets and of the normalised major-axis coordinate.
- Y_WIDTH, 7, width of y offsets and of the normalised minor-axis coordinate; must be < X_WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- line_valid  in  1  line request present.
- line_ready  out  1  block can accept a request.
- dx  in  X_WIDTH  signed two's-complement x offset.
- dy  in  Y_WIDTH  signed two's-complement y offset.
- pt_valid  out  1  normalised point present.
- pt_ready  in  1  downstream accepts point.
- x_norm  out  X_WIDTH  normalised major-axis coordinate (unsigned).
- y_norm  out  Y_WIDTH  normalised minor-axis coordinate (unsigned).
- flip_x  out  1  negate the normalised major axis downstream.
- flip_y  out  1  negate the normalised minor axis downstream.
- flip_identity  out  1  axes swapped downstream.
- pt_last  out  1  final point of the current line.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high; reset mid-line aborts it.
- Reset values: state IDLE, line_ready=1, pt_valid=0, pt_last=0, all flags=0, x_norm=0, y_norm=0.
- States: IDLE, SETUP, STEP.
- IDLE: line_ready=1. line_valid=1 latches dx, dy and moves to SETUP.
- SETUP: one cycle, line_ready=0.
  - Compute ax=|dx| and ay=|dy| (unsigned; |-128|=128 and |-64|=64 are representable).
  - swap = (ay > ax), strict; ties do not swap.
  - Major axis a = swap ? ay : ax; minor axis b = swap ? ax : ay.
  - flip_identity = swap.
  - flip_x = swap ? dy<0 : dx<0.
  - flip_y = swap ? dx<0 : dy<0.
  - err = 2b - a, signed ERR_W = X_WIDTH+2 bits.
  - x_norm=0, y_norm=0. Go to STEP with pt_valid=1.
- Latency: request accepted at cycle N; first point valid at N+2.
- STEP: pt_valid=1. All outputs hold stable while pt_ready=0.
  - On a handshake with x_norm != a:
    - If err > 0: y_norm += 1 and err += 2(b - a).
    - Otherwise: err += 2b.
    - In both cases x_norm += 1.
  - pt_last = (x_norm == a), combinational from registered values.
  - Handshake with pt_last=1: pt_valid goes to 0 next cycle and the state returns to IDLE.
- A line of major length a emits a+1 points, from (0,0) to (a,b) inclusive.
- Zero-length line (dx=dy=0): exactly one point (0,0) with pt_last=1.
- Flags are constant for the whole line and change only in SETUP.
- line_ready is 0 outside IDLE. No new line is accepted in the cycle the last point is consumed; line_ready rises the following cycle.
- Arithmetic: x_norm never exceeds 128 and y_norm never exceeds 64. No wrap is legal; overflow is a design error.

Optional Feature:
- Macro: BRESENHAM_OMIT_END_EN.
- Defined: the endpoint (a,b) is not emitted.
  - pt_last is asserted on the point with x_norm == a-1.
  - Zero-length lines go SETUP -> IDLE with no point emitted (pt_valid stays 0).
  - Use case: free-space-only ray marking.
- Undefined: behaviour as above, endpoint included.

Decomposition:
- bresenham_pkg holds:
  - X_WIDTH/Y_WIDTH defaults;
  - ERR_WIDTH = X_WIDTH+2;
  - the state enum {IDLE, SETUP, STEP};
  - a packed struct for a normalised point (x, y, flip_x, flip_y, flip_identity, last), shared with the flip stage.
- One combinational sub-module, octant_normalize: dx, dy -> a, b, swap, flip_x, flip_y, err_init. It is instantiated in SETUP.

Test Plan:
- dx=5, dy=2, pt_ready=1 -> 6 points: (0,0)(1,0)(2,1)(3,1)(4,2)(5,2); flags 0/0/0; pt_last on (5,2); first pt_valid 2 cycles after acceptance.
- dx=-3, dy=6 -> flip_identity=1, flip_x=0, flip_y=1; 7 points with x_norm 0..6 and y_norm ending at 3.
- dx=-128, dy=-64 -> a=128, b=64, flip_x=1, flip_y=1, no swap; 129 points; final point (128,64); no overflow.
- dx=0, dy=0 -> single point (0,0) with pt_last=1. With BRESENHAM_OMIT_END_EN defined, no point is emitted and line_ready returns 2 cycles after acceptance.
- dx=4, dy=4 with pt_ready toggled randomly -> no swap; points (0,0)..(4,4) diagonal; outputs stable during stalls; no point dropped or duplicated.
- Reset asserted during STEP of dx=10, dy=3 -> next cycle pt_valid=0, line_ready=1, outputs at reset values; a new request dx=2, dy=1 then completes normally.
